// File: rtl/stage_exe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stage_exe_pkg
//  Description : Shared types and constants for the multi-cycle execute
//                stage: FSM state encoding, default widths, bubble values
//                and the ALU opcode map.
//  Revision    : 1.0 - initial release
// ============================================================================
package stage_exe_pkg;

    // Default widths used by stage_exe_mc parameters
    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_W  = 4;
    localparam int DEF_WB_W   = 2;

    // Multiply sequencing FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } exe_state_e;

    // Values written into the control outputs when the stage emits a bubble
    localparam logic BUBBLE_VALID   = 1'b0;
    localparam logic BUBBLE_WBI_BIT = 1'b0;
    localparam logic BUBBLE_M       = 1'b0;
    localparam logic BUBBLE_USE_NPC = 1'b1;

    // ALU opcode encoding
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_NOR  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

endpackage : stage_exe_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Combinational single-cycle ALU with zero flag.
//  Ports       : alu_op_i  - opcode (stage_exe_pkg ALU_* encoding)
//                a_i, b_i  - operands
//                result_o  - result
//                zero_o    - result is all zeros
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
    import stage_exe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        alu_op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    always_comb begin
        result_o = '0;
        case (alu_op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_NOR:  result_o = ~(a_i | b_i);
            ALU_SLT:  result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule : alu
`default_nettype wire

// File: rtl/stage_exe_mc_mul.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iter
//  Description : Iterative shift-add multiplier, one partial product per
//                clock. Produces the low DATA_W bits of a*b, which are the
//                same for unsigned and two's-complement operands.
//  Ports       : clk_i, rst_i - clock, async active-high reset
//                start_i      - latch operands, clear acc/cnt, begin
//                abort_i      - cancel any running multiply (cnt -> 0)
//                a_i, b_i     - operands sampled on start_i
//                busy_o       - iteration in progress
//                done_o       - this cycle performs the final step
//                product_o    - accumulated product (stable once idle)
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] mcand_q;   // multiplicand, shifted left each step
    logic [DATA_W-1:0] mplier_q;  // multiplier, shifted right each step
    logic [DATA_W-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;

    assign done_o    = busy_q & (cnt_q == CNT_LAST);
    assign busy_o    = busy_q;
    assign product_o = acc_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (abort_i) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            // Counter stops on the last step so it never wraps
            if (cnt_q == CNT_LAST) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule : mul_iter
`default_nettype wire

// File: rtl/stage_exe_mc.sv
`default_nettype none
// ============================================================================
//  Module      : stage_exe_mc
//  Description : Multi-cycle MIPS execute stage. Single-cycle ALU ops finish
//                in one clock; multiplies run on an iterative multiplier and
//                stall upstream until the product is ready. Supports a
//                valid/bubble path plus downstream hold and flush.
//  Ports       : clock, reset                 - clock, async active-high reset
//                in_valid, data_a/b/imm, npc  - incoming instruction
//                control_*                    - decoded execute controls
//                wbi, M, regaddr              - pass-through controls
//                hold, flush                  - downstream back-pressure / kill
//                stall                        - upstream must hold inputs
//                out_valid, out, use_npc,
//                jump_address, wbi_o, M_o,
//                regaddr_o, data_b_o          - registered stage outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module stage_exe_mc
    import stage_exe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int WB_W   = DEF_WB_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] data_imm,
    input  logic [DATA_W-1:0] npc,
    input  logic [2:0]        control_alu_op,
    input  logic              control_use_b,
    input  logic              control_is_branch,
    input  logic              control_is_mul,
    input  logic [WB_W-1:0]   wbi,
    input  logic              M,
    input  logic [REG_W-1:0]  regaddr,
    input  logic              hold,
    input  logic              flush,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] out,
    output logic              use_npc,
    output logic [DATA_W-1:0] jump_address,
    output logic [WB_W-1:0]   wbi_o,
    output logic              M_o,
    output logic [REG_W-1:0]  regaddr_o,
    output logic [DATA_W-1:0] data_b_o
);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_b_entry;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_zero;
    logic [DATA_W-1:0] w_jump_sum;

    assign w_b_entry  = control_use_b ? data_b : data_imm;
    assign w_jump_sum = npc + data_imm;

    alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .alu_op_i (control_alu_op),
        .a_i      (data_a),
        .b_i      (w_b_entry),
        .result_o (w_alu_res),
        .zero_o   (w_alu_zero)
    );

    logic              w_mul_start;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_mul_product;

    mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk_i     (clock),
        .rst_i     (reset),
        .start_i   (w_mul_start),
        .abort_i   (flush),
        .a_i       (data_a),
        .b_i       (w_b_entry),
        .busy_o    (w_mul_busy),
        .done_o    (w_mul_done),
        .product_o (w_mul_product)
    );

    // ------------------------------------------------------------------
    // Multiply FSM: state register
    // ------------------------------------------------------------------
    exe_state_e state_q, state_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Multiply FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_mul_start)         state_d = ST_MUL;
            ST_MUL:  if (flush)               state_d = ST_IDLE;
                     else if (w_mul_done)     state_d = ST_DONE;
            ST_DONE: if (flush || !hold)      state_d = ST_IDLE;
            default:                          state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiply FSM: outputs
    // ------------------------------------------------------------------
    logic w_accept;

    always_comb begin
        stall       = hold | (in_valid & control_is_mul & (state_q != ST_DONE));
        w_mul_start = (state_q == ST_IDLE) & in_valid & control_is_mul & ~flush;
        // The MUL guard only matters if upstream drops the multiply mid-run
        // while presenting something else; such an instruction is not taken.
        w_accept    = in_valid & ~stall & ~flush & (state_q != ST_MUL);
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              use_npc_q, use_npc_d;
    logic [DATA_W-1:0] jump_q, jump_d;
    logic [WB_W-1:0]   wbi_q, wbi_d;
    logic              m_q, m_d;
    logic [REG_W-1:0]  regaddr_q, regaddr_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        use_npc_d   = use_npc_q;
        jump_d      = jump_q;
        wbi_d       = wbi_q;
        m_d         = m_q;
        regaddr_d   = regaddr_q;
        data_b_d    = data_b_q;
        if (w_accept) begin
            // Accept implies no hold and no flush
            out_valid_d = 1'b1;
            jump_d      = w_jump_sum;
            wbi_d       = wbi;
            m_d         = M;
            regaddr_d   = regaddr;
            data_b_d    = data_b;
            if (state_q == ST_DONE) begin
                out_d     = w_mul_product;
                use_npc_d = 1'b1;
            end else begin
                out_d     = w_alu_res;
                use_npc_d = ~(control_is_branch & w_alu_zero);
            end
        end else if (flush || !hold) begin
            // Bubble: only the control fields are cleared; data fields keep
            // their last value.
            out_valid_d = BUBBLE_VALID;
            wbi_d       = {WB_W{BUBBLE_WBI_BIT}};
            m_d         = BUBBLE_M;
            use_npc_d   = BUBBLE_USE_NPC;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            use_npc_q   <= 1'b1;
            jump_q      <= '0;
            wbi_q       <= '0;
            m_q         <= 1'b0;
            regaddr_q   <= '0;
            data_b_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            use_npc_q   <= use_npc_d;
            jump_q      <= jump_d;
            wbi_q       <= wbi_d;
            m_q         <= m_d;
            regaddr_q   <= regaddr_d;
            data_b_q    <= data_b_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out          = out_q;
    assign use_npc      = use_npc_q;
    assign jump_address = jump_q;
    assign wbi_o        = wbi_q;
    assign M_o          = m_q;
    assign regaddr_o    = regaddr_q;
    assign data_b_o     = data_b_q;

    // Busy is implied by the FSM state; kept as a port for observability.
    logic w_unused;
    assign w_unused = w_mul_busy;

endmodule : stage_exe_mc
`default_nettype wire

// File: tb/tb_stage_exe_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage_exe_mc
//  Description : Self-checking bench for stage_exe_mc. A 32-bit instance is
//                driven through ALU ops, branches, multiplies, hold, flush
//                and reset; expected results go into a scoreboard queue and
//                are compared when the stage emits a new valid output. An
//                8-bit instance checks multiply latency and wrap-around.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_exe_mc;

    localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] data_a = '0, data_b = '0, data_imm = '0, npc = '0;
    logic [2:0]  alu_op = '0;
    logic        use_b = 1'b0, is_br = 1'b0, is_mul = 1'b0;
    logic [1:0]  wbi = '0;
    logic        m_in = 1'b0;
    logic [3:0]  regaddr = '0;
    logic        hold = 1'b0, flush = 1'b0;

    logic        stall, out_valid, use_npc, M_o;
    logic [31:0] out, jump_address, data_b_o;
    logic [1:0]  wbi_o;
    logic [3:0]  regaddr_o;

    // 8-bit instance, multiply only
    logic        in_valid8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        stall8, out_valid8, use_npc8, M_o8;
    logic [7:0]  out8, jump8, data_b_o8;
    logic [1:0]  wbi_o8;
    logic [3:0]  regaddr_o8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    stage_exe_mc #(.DATA_W(32), .REG_W(4), .WB_W(2)) u_dut (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .data_a(data_a), .data_b(data_b), .data_imm(data_imm), .npc(npc),
        .control_alu_op(alu_op), .control_use_b(use_b),
        .control_is_branch(is_br), .control_is_mul(is_mul),
        .wbi(wbi), .M(m_in), .regaddr(regaddr), .hold(hold), .flush(flush),
        .stall(stall), .out_valid(out_valid), .out(out), .use_npc(use_npc),
        .jump_address(jump_address), .wbi_o(wbi_o), .M_o(M_o),
        .regaddr_o(regaddr_o), .data_b_o(data_b_o)
    );

    stage_exe_mc #(.DATA_W(8), .REG_W(4), .WB_W(2)) u_dut8 (
        .clock(clock), .reset(reset), .in_valid(in_valid8),
        .data_a(a8), .data_b(b8), .data_imm(8'h00), .npc(8'h00),
        .control_alu_op(3'd0), .control_use_b(1'b1),
        .control_is_branch(1'b0), .control_is_mul(1'b1),
        .wbi(2'b00), .M(1'b0), .regaddr(4'h0), .hold(1'b0), .flush(1'b0),
        .stall(stall8), .out_valid(out_valid8), .out(out8), .use_npc(use_npc8),
        .jump_address(jump8), .wbi_o(wbi_o8), .M_o(M_o8),
        .regaddr_o(regaddr_o8), .data_b_o(data_b_o8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        case (op)
            3'd0: return x + y;
            3'd1: return x - y;
            3'd2: return x & y;
            3'd3: return x | y;
            3'd4: return x ^ y;
            3'd5: return ~(x | y);
            3'd6: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            default: return (x < y) ? 32'd1 : 32'd0;
        endcase
    endfunction

    typedef struct packed {
        logic [31:0] res;
        logic        use_npc;
        logic [31:0] jump;
        logic [1:0]  wbi;
        logic        m;
        logic [3:0]  ra;
        logic [31:0] db;
    } exp_t;

    exp_t sb_q[$];

    // Scoreboard monitor: a new output exists after an edge with no hold,
    // no flush and no reset, when out_valid is high.
    logic edge_new = 1'b0;
    always @(posedge clock) edge_new <= !hold && !flush && !reset;

    always @(negedge clock) begin
        if (edge_new && out_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_out", out, e.res);
                check("sb_use_npc", use_npc, e.use_npc);
                check("sb_jump", jump_address, e.jump);
                check("sb_wbi", wbi_o, e.wbi);
                check("sb_M", M_o, e.m);
                check("sb_regaddr", regaddr_o, e.ra);
                check("sb_data_b", data_b_o, e.db);
            end
        end
    end

    // Set up an instruction on the inputs; optionally record its expected result
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc, input logic ub,
                         input logic br, input logic mul, input logic [1:0] w,
                         input logic mm, input logic [3:0] ra, input bit push);
        exp_t e;
        logic [31:0] be;
        be = ub ? b : imm;
        e.res     = mul ? a * be : alu_model(op, a, be);
        e.use_npc = mul ? 1'b1 : !(br && (e.res == 32'd0));
        e.jump    = pc + imm;
        e.wbi     = w;
        e.m       = mm;
        e.ra      = ra;
        e.db      = b;
        alu_op = op; data_a = a; data_b = b; data_imm = imm; npc = pc;
        use_b = ub; is_br = br; is_mul = mul; wbi = w; m_in = mm; regaddr = ra;
        in_valid = 1'b1;
        if (push) sb_q.push_back(e);
    endtask

    // Wait until the presented instruction is taken; returns stalled cycles
    task automatic wait_accept(output int stalls);
        stalls = 0;
        forever begin
            @(negedge clock);
            if (!stall) break;
            stalls++;
            if (stalls > 200) begin
                check("accept_timeout", 1, 0);
                break;
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic present(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [31:0] pc, input logic ub,
                           input logic br, input logic mul, input logic [1:0] w,
                           input logic mm, input logic [3:0] ra, output int stalls);
        drive(op, a, b, imm, pc, ub, br, mul, w, mm, ra, 1'b1);
        wait_accept(stalls);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        is_mul = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic mul8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
        int n;
        a8 = a; b8 = b; in_valid8 = 1'b1; n = 0;
        forever begin
            @(negedge clock);
            if (!stall8) break;
            n++;
            if (n > 100) begin
                check("mul8_timeout", 1, 0);
                break;
            end
        end
        @(posedge clock); #1;
        in_valid8 = 1'b0;
        check("mul8_stall_cycles", n, 9);
        check("mul8_out", out8, exp);
        check("mul8_valid", out_valid8, 1);
        check("mul8_use_npc", use_npc8, 1);
        check("mul8_jump", jump8, 0);
        check("mul8_wbi", wbi_o8, 0);
        check("mul8_M", M_o8, 0);
        check("mul8_regaddr", regaddr_o8, 0);
        check("mul8_data_b", data_b_o8, b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        // ---------------- reset values ----------------
        repeat (2) @(posedge clock);
        #1;
        check("rst_out", out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_use_npc", use_npc, 1);
        check("rst_jump", jump_address, 0);
        check("rst_wbi", wbi_o, 0);
        check("rst_M", M_o, 0);
        check("rst_regaddr", regaddr_o, 0);
        check("rst_data_b", data_b_o, 0);
        check("rst_stall", stall, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // ---------------- add with wrap, then bubble ----------------
        present(OP_ADD, 32'hFFFF_FFFF, 32'h1234, 32'h1, 32'h100, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 4'd5, s);
        check("add_no_stall", s, 0);
        idle(1);
        check("bub_valid", out_valid, 0);
        check("bub_use_npc", use_npc, 1);
        check("bub_M", M_o, 0);
        check("bub_wbi", wbi_o, 0);
        check("bub_out_kept", out, 0);
        check("bub_jump_kept", jump_address, 32'h101);
        check("bub_regaddr_kept", regaddr_o, 5);
        check("bub_data_b_kept", data_b_o, 32'h1234);

        // ---------------- branches, back-to-back ----------------
        present(OP_SUB, 32'd9, 32'd9, 32'h10, 32'h200, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 4'd1, s);
        present(OP_SUB, 32'd9, 32'd4, 32'h20, 32'h300, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 4'd2, s);
        present(OP_SUB, 32'd4, 32'd4, 32'h30, 32'h400, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 4'd3, s);
        idle(1);
        check("br_bub_use_npc", use_npc, 1);
        check("br_bub_M", M_o, 0);

        // ---------------- random single-cycle ops ----------------
        for (int i = 0; i < 12; i++) begin
            present(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)), s);
        end
        idle(1);

        // ---------------- 32-bit multiplies, back-to-back ----------------
        present(OP_ADD, 32'd13, 32'd11, 32'd0, 32'h40, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 4'd7, s);
        check("mul32_stall_a", s, 33);
        present(OP_SUB, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'h80, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 4'd8, s);
        check("mul32_stall_b", s, 33);
        idle(1);

        // ---------------- hold freezes outputs ----------------
        present(OP_ADD, 32'd3, 32'd4, 32'd0, 32'h10, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 4'd9, s);
        in_valid = 1'b0;
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check("hold_valid", out_valid, 1);
            check("hold_out", out, 7);
        end
        hold = 1'b0;
        idle(1);
        check("post_hold_bubble", out_valid, 0);

        // ---------------- hold while multiply runs: DONE waits ----------------
        drive(OP_ADD, 32'd6, 32'd7, 32'd0, 32'h20, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 4'd4, 1'b1);
        repeat (5) @(posedge clock);
        #1;
        hold = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        check("hold_mul_state_done", u_dut.state_q, 2);
        check("hold_mul_stall", stall, 1);
        check("hold_mul_no_valid", out_valid, 0);
        hold = 1'b0;
        wait_accept(s);
        check("hold_mul_accept_now", s, 0);
        idle(1);

        // ---------------- flush at cnt=3 ----------------
        drive(OP_ADD, 32'd5, 32'd5, 32'd0, 32'h0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 4'd2, 1'b0);
        repeat (4) @(posedge clock);
        #1;
        check("flush_cnt3", u_dut.u_mul.cnt_q, 3);
        check("flush_pre_state", u_dut.state_q, 1);
        flush = 1'b1;
        in_valid = 1'b0;
        is_mul = 1'b0;
        @(posedge clock); #1;
        flush = 1'b0;
        check("flush_valid", out_valid, 0);
        check("flush_use_npc", use_npc, 1);
        check("flush_state", u_dut.state_q, 0);
        check("flush_stall", stall, 0);

        // ---------------- flush + hold with valid instruction ----------------
        present(OP_SUB, 32'd8, 32'd8, 32'd4, 32'h50, 1'b1, 1'b1, 1'b0, 2'b11, 1'b1, 4'd6, s);
        drive(OP_ADD, 32'd1, 32'd2, 32'd0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 4'd1, 1'b0);
        hold = 1'b1;
        flush = 1'b1;
        @(posedge clock); #1;
        hold = 1'b0;
        flush = 1'b0;
        check("fh_valid", out_valid, 0);
        check("fh_use_npc", use_npc, 1);
        check("fh_wbi", wbi_o, 0);
        check("fh_M", M_o, 0);
        check("fh_out_kept", out, 0);
        present(OP_ADD, 32'd20, 32'd22, 32'd0, 32'h60, 1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 4'd3, s);
        idle(1);

        // ---------------- reset mid-multiply ----------------
        drive(OP_ADD, 32'd100, 32'd3, 32'd0, 32'h0, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 4'd15, 1'b0);
        repeat (6) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("rmid_out", out, 0);
        check("rmid_valid", out_valid, 0);
        check("rmid_use_npc", use_npc, 1);
        check("rmid_jump", jump_address, 0);
        check("rmid_wbi", wbi_o, 0);
        check("rmid_M", M_o, 0);
        check("rmid_regaddr", regaddr_o, 0);
        check("rmid_data_b", data_b_o, 0);
        check("rmid_state", u_dut.state_q, 0);
        in_valid = 1'b0;
        is_mul = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        present(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 4'd1, s);
        check("post_reset_add", out, 12);
        idle(2);

        // ---------------- 8-bit multiplies ----------------
        mul8(8'd13, 8'd11, 8'd143);
        mul8(8'hFF, 8'hFF, 8'h01);

        idle(3);
        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_stage_exe_mc
`default_nettype wire
